// File: rtl/gcd_ctrl.sv
// Subtractive GCD: N subtractions -> done pulse N+3 cycles after accept (2 if an operand is 0); define GCD_ITER_COUNT_EN for iter_cnt.
// Backpressure: start is only accepted in IDLE; requests while busy or done are dropped, not queued.
module gcd_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] x_in,
    input  logic [WIDTH-1:0] y_in,
    output logic             busy,
    output logic             done,
`ifdef GCD_ITER_COUNT_EN
    output logic [WIDTH-1:0] iter_cnt,
`endif
    output logic [WIDTH-1:0] result
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] xr_q, xr_d;
    logic [WIDTH-1:0] yr_q, yr_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             neq;
    logic             x_gt_y;

`ifdef GCD_ITER_COUNT_EN
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] iter_cnt_q, iter_cnt_d;
`endif

    assign neq    = (xr_q != yr_q);
    assign x_gt_y = (xr_q > yr_q);

    always_comb begin
        state_d  = state_q;
        xr_d     = xr_q;
        yr_d     = yr_q;
        result_d = result_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
`ifdef GCD_ITER_COUNT_EN
        cnt_d      = cnt_q;
        iter_cnt_d = iter_cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    xr_d    = x_in;
                    yr_d    = y_in;
                    busy_d  = 1'b1;
                    state_d = CHECK;
`ifdef GCD_ITER_COUNT_EN
                    cnt_d = '0;
`endif
                end
            end
            CHECK: begin
                if ((xr_q == '0) || (yr_q == '0)) begin
                    // gcd(a,0) = a; both zero yields 0
                    result_d = xr_q | yr_q;
                    busy_d   = 1'b0;
                    done_d   = 1'b1;
                    state_d  = DONE;
`ifdef GCD_ITER_COUNT_EN
                    iter_cnt_d = cnt_q;
`endif
                end else begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (!neq) begin
                    result_d = xr_q;
                    busy_d   = 1'b0;
                    done_d   = 1'b1;
                    state_d  = DONE;
`ifdef GCD_ITER_COUNT_EN
                    iter_cnt_d = cnt_q;
`endif
                end else begin
                    // larger operand is always the minuend, so no wrap
                    if (x_gt_y) xr_d = xr_q - yr_q;
                    else        yr_d = yr_q - xr_q;
`ifdef GCD_ITER_COUNT_EN
                    if (cnt_q != {WIDTH{1'b1}}) cnt_d = cnt_q + 1'b1;
`endif
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            xr_q     <= '0;
            yr_q     <= '0;
            result_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
`ifdef GCD_ITER_COUNT_EN
            cnt_q      <= '0;
            iter_cnt_q <= '0;
`endif
        end else begin
            state_q  <= state_d;
            xr_q     <= xr_d;
            yr_q     <= yr_d;
            result_q <= result_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
`ifdef GCD_ITER_COUNT_EN
            cnt_q      <= cnt_d;
            iter_cnt_q <= iter_cnt_d;
`endif
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;
`ifdef GCD_ITER_COUNT_EN
    assign iter_cnt = iter_cnt_q;
`endif

endmodule
